// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcode/funct values,
// datapath select codes, state encoding and the instruction-class record.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;

    localparam logic [1:0] EOP_ZERO = 2'd0;
    localparam logic [1:0] EOP_SIGN = 2'd1;
    localparam logic [1:0] EOP_LUI  = 2'd2;
    localparam logic [1:0] EOP_SHL2 = 2'd3;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_J    = 2'd2;
    localparam logic [1:0] NPC_RS   = 2'd3;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_DM    = 2'd1;
    localparam logic [1:0] WD_PC4   = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // One-hot instruction class; all-zero means unsupported.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic addiu;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle. The controller is the master: it reads the
// IR fields, ALU zero and memory ready, and drives every select/enable.
interface mc_ctrl_if #(
    parameter int ALUOP_W = 3,
    parameter int NPCOP_W = 2
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               dm_ready;

    logic               pc_wr;
    logic [NPCOP_W-1:0] npc_op;
    logic               ir_wr;
    logic               rf_wr;
    logic [1:0]         reg_dst;
    logic [1:0]         wd_sel;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         eop;
    logic               dm_rd;
    logic               dm_wr;
    logic               instr_done;
    logic               illegal;

    modport master (
        input  op, funct, zero, dm_ready,
        output pc_wr, npc_op, ir_wr, rf_wr, reg_dst, wd_sel, alu_src,
               alu_op, eop, dm_rd, dm_wr, instr_done, illegal
    );

    modport slave (
        output op, funct, zero, dm_ready,
        input  pc_wr, npc_op, ir_wr, rf_wr, reg_dst, wd_sel, alu_src,
               alu_op, eop, dm_rd, dm_wr, instr_done, illegal
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct classifier: one-hot instruction class plus illegal.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output iclass_t    o_class,
    output logic       o_illegal
);
    iclass_t w_class;

    // Map opcode (and funct for R-type) onto exactly one class bit.
    always_comb begin
        w_class = '0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: w_class.addu = 1'b1;
                    FN_SUBU: w_class.subu = 1'b1;
                    FN_JR:   w_class.jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:   w_class.ori   = 1'b1;
            OP_ADDIU: w_class.addiu = 1'b1;
            OP_LUI:   w_class.lui   = 1'b1;
            OP_LW:    w_class.lw    = 1'b1;
            OP_SW:    w_class.sw    = 1'b1;
            OP_BEQ:   w_class.beq   = 1'b1;
            OP_J:     w_class.j     = 1'b1;
            OP_JAL:   w_class.jal   = 1'b1;
            default:  ;
        endcase
    end

    assign o_class   = w_class;
    assign o_illegal = (w_class == '0);
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXE/MEM/WB sequencing with
// combinational outputs from state, class and zero; all outputs forced to 0
// while reset is high so no write can slip out during an abort.
module mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int NPCOP_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_if.master     bus
);
    state_t  r_state;
    state_t  w_next;
    iclass_t w_cls;
    logic    w_ill;

    logic       w_pc_wr, w_ir_wr, w_rf_wr, w_alu_src, w_dm_rd, w_dm_wr;
    logic       w_instr_done, w_illegal;
    logic [1:0] w_npc_op, w_reg_dst, w_wd_sel, w_eop;
    logic [2:0] w_alu_op;
    // Per-class ALU/extender settings, shared by EXE, MEM and WB so the
    // datapath result is held steady until it is written.
    logic       w_x_src;
    logic [2:0] w_x_op;
    logic [1:0] w_x_eop;

    mc_ctrl_decode u_decode (
        .i_op      (bus.op),
        .i_funct   (bus.funct),
        .o_class   (w_cls),
        .o_illegal (w_ill)
    );

    // State register; reset aborts the current instruction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next-state selection; unused codes fall back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = (w_ill || w_cls.j || w_cls.jal || w_cls.jr) ? S_FETCH : S_EXE;
            S_EXE: begin
                if (w_cls.lw || w_cls.sw) w_next = S_MEM;
                else if (w_cls.beq)       w_next = S_FETCH;
                else                      w_next = S_WB;
            end
            S_MEM: begin
                if (!bus.dm_ready)  w_next = S_MEM;
                else if (w_cls.lw)  w_next = S_WB;
                else                w_next = S_FETCH;
            end
            default:  w_next = S_FETCH;
        endcase
    end

    // ALU source, operation and extender mode per instruction class.
    always_comb begin
        w_x_src = 1'b0;
        w_x_op  = ALU_ADD;
        w_x_eop = EOP_ZERO;
        if (w_cls.subu) w_x_op = ALU_SUB;
        if (w_cls.ori) begin
            w_x_src = 1'b1;
            w_x_op  = ALU_OR;
        end
        if (w_cls.addiu || w_cls.lw || w_cls.sw) begin
            w_x_src = 1'b1;
            w_x_eop = EOP_SIGN;
        end
        if (w_cls.lui) begin
            w_x_src = 1'b1;
            w_x_eop = EOP_LUI;
        end
        if (w_cls.beq) begin
            w_x_op  = ALU_SUB;
            w_x_eop = EOP_SHL2;
        end
    end

    // Datapath controls for the current state.
    always_comb begin
        w_pc_wr      = 1'b0;
        w_npc_op     = NPC_PC4;
        w_ir_wr      = 1'b0;
        w_rf_wr      = 1'b0;
        w_reg_dst    = RD_RT;
        w_wd_sel     = WD_ALU;
        w_alu_src    = 1'b0;
        w_alu_op     = ALU_ADD;
        w_eop        = EOP_ZERO;
        w_dm_rd      = 1'b0;
        w_dm_wr      = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_wr = 1'b1;
                w_pc_wr = 1'b1;
            end
            S_DECODE: begin
                w_eop     = EOP_SHL2;
                w_illegal = w_ill;
                if (w_cls.j || w_cls.jal) begin
                    w_pc_wr      = 1'b1;
                    w_npc_op     = NPC_J;
                    w_instr_done = 1'b1;
                end
                if (w_cls.jal) begin
                    w_rf_wr   = 1'b1;
                    w_reg_dst = RD_RA;
                    w_wd_sel  = WD_PC4;
                end
                if (w_cls.jr) begin
                    w_pc_wr      = 1'b1;
                    w_npc_op     = NPC_RS;
                    w_instr_done = 1'b1;
                end
            end
            S_EXE: begin
                w_alu_src = w_x_src;
                w_alu_op  = w_x_op;
                w_eop     = w_x_eop;
                if (w_cls.beq) begin
                    w_npc_op     = NPC_BR;
                    w_pc_wr      = bus.zero;
                    w_instr_done = 1'b1;
                end
            end
            S_MEM: begin
                if (w_cls.lw || w_cls.sw) begin
                    w_alu_src = w_x_src;
                    w_alu_op  = w_x_op;
                    w_eop     = w_x_eop;
                end
                w_dm_rd      = w_cls.lw;
                w_dm_wr      = w_cls.sw;
                w_instr_done = w_cls.sw && bus.dm_ready;
            end
            S_WB: begin
                w_alu_src    = w_x_src;
                w_alu_op     = w_x_op;
                w_eop        = w_x_eop;
                w_rf_wr      = 1'b1;
                w_instr_done = 1'b1;
                w_reg_dst    = (w_cls.addu || w_cls.subu) ? RD_RD : RD_RT;
                w_wd_sel     = w_cls.lw ? WD_DM : WD_ALU;
            end
            default: ;
        endcase
    end

    assign bus.pc_wr      = reset ? 1'b0 : w_pc_wr;
    assign bus.npc_op     = reset ? '0   : NPCOP_W'(w_npc_op);
    assign bus.ir_wr      = reset ? 1'b0 : w_ir_wr;
    assign bus.rf_wr      = reset ? 1'b0 : w_rf_wr;
    assign bus.reg_dst    = reset ? 2'd0 : w_reg_dst;
    assign bus.wd_sel     = reset ? 2'd0 : w_wd_sel;
    assign bus.alu_src    = reset ? 1'b0 : w_alu_src;
    assign bus.alu_op     = reset ? '0   : ALUOP_W'(w_alu_op);
    assign bus.eop        = reset ? 2'd0 : w_eop;
    assign bus.dm_rd      = reset ? 1'b0 : w_dm_rd;
    assign bus.dm_wr      = reset ? 1'b0 : w_dm_wr;
    assign bus.instr_done = reset ? 1'b0 : w_instr_done;
    assign bus.illegal    = reset ? 1'b0 : w_illegal;
endmodule
